// File: rtl/sysex_param_tx.sv
// Purpose: encodes one parameter write into the 7-byte SysEx message F0 7D {1,ch} bank adr data F7 and sends it as 8N1 MIDI on midi_txd.
// Latency: start bit appears the cycle after accept; the message lasts 7*(9+STOP_BITS)*BAUD_DIV cycles; msg_done pulses in the first idle cycle.
// Backpressure: req_ready is high only while idle; requests seen while busy are dropped, so the requester holds req_valid until req_ready.
module sysex_param_tx #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int BAUD      = 31_250,
   parameter int STOP_BITS = 1
) (
   input  logic       sys_clk,
   input  logic       reset_reg_N,
   input  logic [3:0] midi_ch,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_bank,
   input  logic [6:0] req_adr,
   input  logic [7:0] req_data,
   output logic       midi_txd,
   output logic       tx_active,
   output logic [2:0] tx_byte_idx,
   output logic       msg_done
);

   localparam int            BAUD_DIV  = CLK_HZ / BAUD;
   localparam int            TW        = $clog2(BAUD_DIV);
   localparam logic [TW-1:0] TMR_LAST  = TW'(BAUD_DIV - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] bit_tmr;
   logic [2:0]    bit_cnt;      // data bit index in DATA, stop bit index in STOP
   logic [2:0]    byte_cnt;
   logic [3:0]    ch_q;
   logic [2:0]    bank_q;
   logic [6:0]    adr_q;
   logic [6:0]    data_q;
   logic          done_q;
   logic [7:0]    cur_byte;
   logic          bit_end, data_end, stop_end, last_byte, accept;

   assign bit_end   = (bit_tmr == TMR_LAST);
   assign data_end  = bit_end && (bit_cnt == 3'd7);
   assign stop_end  = bit_end && (bit_cnt == STOP_LAST);
   assign last_byte = (byte_cnt == 3'd6);
   assign accept    = (state == S_IDLE) && req_valid;

   // state register
   always_ff @(posedge sys_clk or negedge reset_reg_N) begin
      if (!reset_reg_N) state <= S_IDLE;
      else              state <= state_nxt;
   end

   // next-state logic: one start, eight data, STOP_BITS stop periods per byte
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req_valid) state_nxt = S_START;
         S_START: if (bit_end)   state_nxt = S_DATA;
         S_DATA:  if (data_end)  state_nxt = S_STOP;
         S_STOP:  if (stop_end)  state_nxt = last_byte ? S_IDLE : S_START;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // output decode from registered state, so the line reacts to reset at once
   always_comb begin
      midi_txd  = 1'b1;
      req_ready = 1'b0;
      tx_active = 1'b1;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            tx_active = 1'b0;
         end
         S_START: midi_txd = 1'b0;
         S_DATA:  midi_txd = cur_byte[bit_cnt];
         default: ;
      endcase
   end

   // byte currently being shifted, built from the captured request
   always_comb begin
      case (byte_cnt)
         3'd0:    cur_byte = 8'hF0;
         3'd1:    cur_byte = 8'h7D;
         3'd2:    cur_byte = {4'h1, ch_q};
         3'd3:    cur_byte = {5'b0, bank_q};
         3'd4:    cur_byte = {1'b0, adr_q};
         3'd5:    cur_byte = {1'b0, data_q};
         default: cur_byte = 8'hF7;
      endcase
   end

   // bit timer, bit/byte counters, request capture and end-of-message pulse
   always_ff @(posedge sys_clk or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         bit_tmr  <= '0;
         bit_cnt  <= 3'd0;
         byte_cnt <= 3'd0;
         ch_q     <= 4'd0;
         bank_q   <= 3'd0;
         adr_q    <= 7'd0;
         data_q   <= 7'd0;
         done_q   <= 1'b0;
      end else begin
         if (state == S_IDLE || bit_end) bit_tmr <= '0;
         else                            bit_tmr <= bit_tmr + TW'(1);

         case (state)
            S_DATA:  if (bit_end) bit_cnt <= data_end ? 3'd0 : bit_cnt + 3'd1;
            S_STOP:  if (bit_end) bit_cnt <= stop_end ? 3'd0 : bit_cnt + 3'd1;
            default: bit_cnt <= 3'd0;
         endcase

         if (state == S_STOP && stop_end)
            byte_cnt <= last_byte ? 3'd0 : byte_cnt + 3'd1;

         done_q <= (state == S_STOP) && stop_end && last_byte;

         if (accept) begin
            ch_q   <= midi_ch;
            bank_q <= req_bank;
            adr_q  <= req_adr;
            data_q <= req_data[6:0];
         end
      end
   end

   assign tx_byte_idx = byte_cnt;
   assign msg_done    = done_q;

endmodule

// File: tb/tb_sysex_param_tx.sv
// Bench for sysex_param_tx: two instances (BAUD_DIV=10/1 stop bit and BAUD_DIV=4/2 stop bits).
// A UART monitor decodes the selected line and pops expected bytes pushed when each request is driven.
// Frame spacing, byte index, end-pulse timing, back-to-back spacing and async reset are checked.
module tb_sysex_param_tx;

   localparam int DIV1 = 10, FRAME1 = 100, MSG1 = 700;
   localparam int DIV2 = 4,  FRAME2 = 44,  MSG2 = 308;

   logic       sys_clk = 1'b0;
   logic       reset_reg_N, reset2_N;
   logic [3:0] midi_ch;
   logic       req_valid, req_valid2;
   logic [2:0] req_bank;
   logic [6:0] req_adr;
   logic [7:0] req_data;
   logic       req_ready, midi_txd, tx_active, msg_done;
   logic [2:0] tx_byte_idx;
   logic       rdy2, txd2, act2, done2;
   logic [2:0] idx2;

   always #5 sys_clk = ~sys_clk;

   sysex_param_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .STOP_BITS(1)) dut (
      .sys_clk(sys_clk), .reset_reg_N(reset_reg_N), .midi_ch(midi_ch),
      .req_valid(req_valid), .req_ready(req_ready), .req_bank(req_bank),
      .req_adr(req_adr), .req_data(req_data), .midi_txd(midi_txd),
      .tx_active(tx_active), .tx_byte_idx(tx_byte_idx), .msg_done(msg_done));

   sysex_param_tx #(.CLK_HZ(400_000), .BAUD(100_000), .STOP_BITS(2)) dut2 (
      .sys_clk(sys_clk), .reset_reg_N(reset2_N), .midi_ch(midi_ch),
      .req_valid(req_valid2), .req_ready(rdy2), .req_bank(req_bank),
      .req_adr(req_adr), .req_data(req_data), .midi_txd(txd2),
      .tx_active(act2), .tx_byte_idx(idx2), .msg_done(done2));

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] b;
      logic [2:0] idx;
      int         gap;
   } exp_t;
   exp_t sb_q[$];

   // selected instance
   bit   mon_sel = 1'b0;
   int   mon_div = DIV1;
   logic m_txd, m_act, m_rdy, m_done, m_rst;
   logic [2:0] m_idx;
   assign m_txd  = mon_sel ? txd2  : midi_txd;
   assign m_act  = mon_sel ? act2  : tx_active;
   assign m_rdy  = mon_sel ? rdy2  : req_ready;
   assign m_done = mon_sel ? done2 : msg_done;
   assign m_idx  = mon_sel ? idx2  : tx_byte_idx;
   assign m_rst  = mon_sel ? reset2_N : reset_reg_N;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] msg_byte(input int i, input logic [3:0] ch, input logic [2:0] bank,
                                           input logic [6:0] adr, input logic [7:0] data);
      case (i)
         0:       return 8'hF0;
         1:       return 8'h7D;
         2:       return {4'h1, ch};
         3:       return {5'b0, bank};
         4:       return {1'b0, adr};
         5:       return {1'b0, data[6:0]};
         default: return 8'hF7;
      endcase
   endfunction

   task automatic push_msg(input logic [3:0] ch, input logic [2:0] bank, input logic [6:0] adr,
                           input logic [7:0] data, input int first_gap, input int frame);
      exp_t e;
      for (int i = 0; i < 7; i++) begin
         e.b   = msg_byte(i, ch, bank, adr, data);
         e.idx = 3'(i);
         e.gap = (i == 0) ? first_gap : frame;
         sb_q.push_back(e);
      end
   endtask

   // UART monitor: detects the start edge, samples mid-bit, checks frame spacing
   initial begin
      bit         m_busy  = 1'b0;
      bit         prev_ok = 1'b0;
      int         m_t = 0, prev_fall = 0, bi;
      logic [7:0] m_sh = 8'h00;
      exp_t       e;
      forever begin
         @(negedge sys_clk);
         if (!m_rst) begin
            m_busy  = 1'b0;
            prev_ok = 1'b0;
         end else if (!m_busy) begin
            if (m_txd == 1'b0) begin
               m_busy = 1'b1;
               m_t    = 0;
               m_sh   = 8'h00;
               chk("start_expected", 32'(sb_q.size() != 0), 32'd1);
               if (sb_q.size() != 0) e = sb_q[0];
               else begin e.b = 8'h00; e.idx = 3'd0; e.gap = 0; end
               if (e.gap != 0 && prev_ok) chk("start_gap", cyc - prev_fall, e.gap);
               prev_fall = cyc;
               prev_ok   = 1'b1;
            end
         end else begin
            m_t++;
            if (m_t % mon_div == mon_div / 2) begin
               bi = m_t / mon_div;
               if (bi == 0) begin
                  chk("start_bit", m_txd, 1'b0);
                  chk("byte_idx", m_idx, e.idx);
                  chk("tx_active_busy", m_act, 1'b1);
               end else if (bi <= 8) begin
                  m_sh[bi-1] = m_txd;
               end else begin
                  chk("stop_bit", m_txd, 1'b1);
                  if (sb_q.size() != 0) begin
                     e = sb_q.pop_front();
                     chk("byte", m_sh, e.b);
                  end
                  m_busy = 1'b0;
               end
            end
         end
      end
   end

   // drive a request; returns cyc of the cycle before the accepting edge
   task automatic send(input logic [3:0] ch, input logic [2:0] bank, input logic [6:0] adr,
                       input logic [7:0] data, input int first_gap, input bit hold, output int acc_c);
      int n = 0;
      @(negedge sys_clk);
      midi_ch  = ch;
      req_bank = bank;
      req_adr  = adr;
      req_data = data;
      if (mon_sel) req_valid2 = 1'b1;
      else         req_valid  = 1'b1;
      push_msg(ch, bank, adr, data, first_gap, mon_sel ? FRAME2 : FRAME1);
      while (!m_rdy && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      chk("accept_in_time", 32'(n < 2000), 32'd1);
      if (n > 0) chk("done_with_ready", m_done, 1'b1);
      acc_c = cyc;
      @(posedge sys_clk);
      #1;
      if (!hold) begin
         req_valid  = 1'b0;
         req_valid2 = 1'b0;
      end
      midi_ch  = ~ch;
      req_bank = ~bank;
      req_adr  = ~adr;
      req_data = ~data;
   endtask

   task automatic wait_done(input int acc_c, input int total);
      int n = 0;
      while (!m_done && n < total + 50) begin
         @(negedge sys_clk);
         n++;
      end
      chk("done_time", cyc - acc_c, total + 1);
      chk("done_ready", m_rdy, 1'b1);
      chk("done_active", m_act, 1'b0);
      chk("done_idx", m_idx, 3'd0);
      chk("done_txd", m_txd, 1'b1);
      @(negedge sys_clk);
      chk("done_one_cycle", m_done, 1'b0);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
   endtask

   initial begin
      int acc, acc2;
      reset_reg_N = 1'b0;
      reset2_N    = 1'b0;
      req_valid   = 1'b0;
      req_valid2  = 1'b0;
      midi_ch     = 4'd0;
      req_bank    = 3'd0;
      req_adr     = 7'd0;
      req_data    = 8'd0;

      // reset idle
      repeat (5) @(negedge sys_clk);
      chk("in_reset", {midi_txd, req_ready, msg_done, tx_active, tx_byte_idx}, 7'b1100_000);
      reset_reg_N = 1'b1;
      reset2_N    = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge sys_clk);
         chk("idle", {midi_txd, req_ready, msg_done, tx_active, tx_byte_idx}, 7'b1100_000);
      end

      // single write
      send(4'd3, 3'd5, 7'h12, 8'h40, 0, 1'b0, acc);
      wait_done(acc, MSG1);

      // high values: bit 7 of data dropped
      send(4'd0, 3'd7, 7'h7F, 8'hFF, 0, 1'b0, acc);
      wait_done(acc, MSG1);

      // back-to-back with req_valid held and inputs changed during message 1
      send(4'hA, 3'd1, 7'h33, 8'h81, 0, 1'b1, acc);
      send(4'h6, 3'd2, 7'h5C, 8'h7E, FRAME1 + 1, 1'b0, acc2);
      chk("b2b_accept_spacing", acc2 - acc, MSG1 + 1);
      wait_done(acc2, MSG1);

      // async reset during byte 3 bit 4
      send(4'd9, 3'd2, 7'h55, 8'h2A, 0, 1'b0, acc);
      while (cyc < acc + 1 + 355) @(negedge sys_clk);
      chk("pre_reset_txd", midi_txd, 1'b0);
      chk("pre_reset_idx", tx_byte_idx, 3'd3);
      reset_reg_N = 1'b0;
      #1;
      chk("async_reset", {midi_txd, req_ready, msg_done, tx_active, tx_byte_idx}, 7'b1100_000);
      sb_q.delete();
      repeat (3) @(posedge sys_clk);
      #2;
      reset_reg_N = 1'b1;
      send(4'd4, 3'd6, 7'h01, 8'h7F, 0, 1'b0, acc);
      wait_done(acc, MSG1);

      // two stop bits, BAUD_DIV=4
      mon_sel = 1'b1;
      mon_div = DIV2;
      send(4'hF, 3'd3, 7'h2B, 8'h11, 0, 1'b0, acc);
      wait_done(acc, MSG2);
      chk("dut1_idle_during_dut2", {midi_txd, req_ready, tx_active}, 3'b110);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
